rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges pipeline (A) and multi-cycle unit (B)
// writebacks onto one registered write port, with starvation protection for B.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,

    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,

    input  logic              hold,

    output logic              write_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,

    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,

    output logic [2:0]        starve_cnt
);

    localparam int unsigned       CNT_W   = 3;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic              write_en_q,   write_en_d;
    logic [ADDR_W-1:0] wb_addr_q,    wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,    wb_data_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              starved_c;
    logic              a_grant_c;
    logic              b_grant_c;

    // Grant logic: A has priority unless B has waited STARVE_MAX cycles.
    // Grants are suppressed while in reset or while the pipeline is frozen.
    always_comb begin
        starved_c = b_valid & (starve_cnt_q >= CNT_MAX);
        a_grant_c = rst & ~hold & a_valid & ~starved_c;
        b_grant_c = rst & ~hold & b_valid & ~a_grant_c;
    end

    // Next-state: starvation counter and the registered write port.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        write_en_d   = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;

        if (!hold) begin
            if (!b_valid || b_grant_c) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q < CNT_MAX) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end

        // Writes to x0 are accepted but never strobed into the file.
        if (a_grant_c) begin
            wb_addr_d  = a_addr;
            wb_data_d  = a_data;
            write_en_d = (a_addr != '0);
        end else if (b_grant_c) begin
            wb_addr_d  = b_addr;
            wb_data_d  = b_data;
            write_en_d = (b_addr != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_en_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            write_en_q   <= write_en_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign a_ready    = a_grant_c;
    assign b_ready    = b_grant_c;
    assign write_en   = write_en_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign starve_cnt = starve_cnt_q;

    // Read-after-write hazard against the write currently on the port; x0 never hazards.
    assign hazard1 = write_en_q & (wb_addr_q == rd_addr1) & (rd_addr1 != '0);
    assign hazard2 = write_en_q & (wb_addr_q == rd_addr2) & (rd_addr2 != '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run against a rule-level reference model.
module tb_rf_wb_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned SMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, hold;
    logic [AW-1:0] a_addr, b_addr, rd_addr1, rd_addr2;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, write_en, hazard1, hazard2;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [2:0]    starve_cnt;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .hold(hold),
        .write_en(write_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; observation happens 1ns later.
    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         input logic h, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        hold = h; rd_addr1 = r1; rd_addr2 = r2;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        hold = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        // Produce a pending write and a nonzero count, then reset with requests active.
        drive(1'b1, 5'd9, 32'hAAAA5555, 1'b1, 5'd4, 32'h1, 1'b0, 5'd9, 5'd9);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en got=%0b exp=0", write_en); end
        checks++; if (wb_addr !== '0) begin errors++; $display("FAIL reset_wb_addr got=%0d exp=0", wb_addr); end
        checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        checks++; if (starve_cnt !== 3'd0) begin errors++; $display("FAIL reset_starve_cnt got=%0d exp=0", starve_cnt); end
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b%0b exp=00", a_ready, b_ready); end
        checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%0b%0b exp=00", hazard1, hazard2); end
        apply_reset();
    endtask

    task automatic test_a_only();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL a_only_ready got=%0b%0b exp=10", a_ready, b_ready); end
        idle();
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL a_only_write_en got=%0b exp=1", write_en); end
        checks++; if (wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL a_only_wb got=%0d/%h exp=5/deadbeef", wb_addr, wb_data); end
        idle();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL a_only_idle_write_en got=%0b exp=0", write_en); end
        checks++; if (wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL a_only_retain got=%0d/%h exp=5/deadbeef", wb_addr, wb_data); end
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, AW'(k + 1), DW'(k), 1'b1, 5'd9, 32'h0B0B0B0B, 1'b0, '0, '0);
            if (k == 3) begin
                checks++; if (starve_cnt !== 3'd3) begin errors++; $display("FAIL starve_cnt_sat got=%0d exp=3", starve_cnt); end
                checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin errors++; $display("FAIL starve_forced_b got=%0b%0b exp=01", a_ready, b_ready); end
            end else begin
                checks++; if (starve_cnt !== ((k == 4) ? 3'd0 : 3'(k))) begin errors++; $display("FAIL starve_cnt_k%0d got=%0d", k, starve_cnt); end
                checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL starve_a_wins_k%0d got=%0b%0b exp=10", k, a_ready, b_ready); end
            end
            if (k == 4) begin
                checks++; if (write_en !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h0B0B0B0B) begin
                    errors++; $display("FAIL starve_b_write got=%0b/%0d/%h exp=1/9/0b0b0b0b", write_en, wb_addr, wb_data); end
            end
        end
        idle();
    endtask

    task automatic test_x0();
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL x0_b_ready got=%0b exp=1", b_ready); end
        idle();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL x0_write_en got=%0b exp=0", write_en); end
        checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL x0_hazard1 got=%0b exp=0", hazard1); end
    endtask

    task automatic test_hazard();
        drive(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd7, 5'd8);
        checks++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin errors++; $display("FAIL hazard_pair got=%0b%0b exp=10", hazard1, hazard2); end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd7, 5'd7);
        checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin errors++; $display("FAIL hazard_no_write got=%0b%0b exp=00", hazard1, hazard2); end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h33, 1'b1, '0, '0);
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || starve_cnt !== 3'd0) begin
                errors++; $display("FAIL hold_k%0d got=%0b%0b cnt=%0d exp=00 cnt=0", k, a_ready, b_ready, starve_cnt); end
        end
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL hold_release got=%0b exp=1", b_ready); end
        // Hold must also freeze a nonzero count.
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h44, 1'b0, '0, '0);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h44, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h44, 1'b1, '0, '0);
            checks++; if (starve_cnt !== 3'd2) begin errors++; $display("FAIL hold_freeze_k%0d got=%0d exp=2", k, starve_cnt); end
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd1, 32'h11, 1'b0, '0, '0);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd1, 32'h11, 1'b0, 5'd6, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (write_en !== 1'b0 || starve_cnt !== 3'd0) begin errors++; $display("FAIL midrst_assert got=%0b cnt=%0d exp=0 cnt=0", write_en, starve_cnt); end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL midrst_release got=%0b exp=0", write_en); end
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd1, 32'h11, 1'b0, '0, '0);
        checks++; if (write_en !== 1'b0 || starve_cnt !== 3'd0 || a_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_first_cycle got=we%0b cnt=%0d a=%0b exp=we0 cnt=0 a=1", write_en, starve_cnt, a_ready); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            drive((k < 4) ? 1'b1 : 1'b0, AW'(k + 10), DW'(32'hC000 + k), 1'b0, '0, '0, 1'b0, '0, '0);
            if (k > 0) begin
                checks++; if (write_en !== 1'b1 || wb_addr !== AW'(k + 9) || wb_data !== DW'(32'hC000 + k - 1)) begin
                    errors++; $display("FAIL b2b_k%0d got=%0b/%0d/%h", k, write_en, wb_addr, wb_data); end
            end
        end
        idle();
    endtask

    // Reference model: grant rules, saturating starvation count, one-cycle write latency.
    task automatic test_random();
        int            m_cnt = 0;
        logic          m_we = 1'b0;
        logic [AW-1:0] m_addr = wb_addr;
        logic [DW-1:0] m_data = wb_data;
        logic          bp = 1'b0;
        logic [AW-1:0] bpa = '0;
        logic [DW-1:0] bpd = '0;
        for (int i = 0; i < 400; i++) begin
            logic av, h, ea, eb;
            logic [AW-1:0] aa, r1, r2;
            logic [DW-1:0] ad;
            if (!bp && $urandom_range(0, 9) < 4) begin
                bp = 1'b1; bpa = AW'($urandom_range(0, 7)); bpd = $urandom;
            end
            av = ($urandom_range(0, 9) < 6);
            aa = AW'($urandom_range(0, 7));
            ad = $urandom;
            h  = ($urandom_range(0, 9) < 2);
            r1 = ($urandom_range(0, 2) == 0) ? m_addr : AW'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 2) == 0) ? m_addr : AW'($urandom_range(0, 7));
            drive(av, aa, ad, bp, bpa, bpd, h, r1, r2);

            ea = av && !h && !(bp && m_cnt >= SMAX);
            eb = bp && !h && !ea;
            checks++; if (a_ready !== ea || b_ready !== eb) begin errors++; $display("FAIL rnd%0d_ready got=%0b%0b exp=%0b%0b", i, a_ready, b_ready, ea, eb); end
            checks++; if (starve_cnt !== 3'(m_cnt)) begin errors++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", i, starve_cnt, m_cnt); end
            checks++; if (write_en !== m_we) begin errors++; $display("FAIL rnd%0d_we got=%0b exp=%0b", i, write_en, m_we); end
            if (m_we) begin
                checks++; if (wb_addr !== m_addr || wb_data !== m_data) begin errors++; $display("FAIL rnd%0d_wb got=%0d/%h exp=%0d/%h", i, wb_addr, wb_data, m_addr, m_data); end
            end
            checks++; if (hazard1 !== (m_we && r1 == m_addr && r1 != 0) || hazard2 !== (m_we && r2 == m_addr && r2 != 0)) begin
                errors++; $display("FAIL rnd%0d_hazard got=%0b%0b", i, hazard1, hazard2); end

            if (!h) m_cnt = (!bp || eb) ? 0 : ((m_cnt < SMAX) ? m_cnt + 1 : m_cnt);
            m_we = 1'b0;
            if (ea) begin m_addr = aa;  m_data = ad;  m_we = (aa != 0); end
            else if (eb) begin m_addr = bpa; m_data = bpd; m_we = (bpa != 0); end
            if (eb) bp = 1'b0;
        end
        idle();
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_a_only();
        test_starvation();
        test_x0();
        test_hazard();
        test_hold();
        test_reset_midflight();
        test_back_to_back();
        apply_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
